// File: rtl/div_arbiter_if.sv
// Connection bundle for div_arbiter: requester handshakes, fp_div operand/result path and debug taps.
// master = requesters plus the fp_div instance, slave = the arbiter itself.
interface div_arbiter_if #(
    parameter int N = 4
);
    localparam int TW = $clog2(N);

    logic [N-1:0]    req;
    logic [32*N-1:0] a_in;
    logic [32*N-1:0] b_in;
    logic [N-1:0]    ack;
    logic [31:0]     div_a;
    logic [31:0]     div_b;
    logic [31:0]     div_q;
    logic [31:0]     q;
    logic [N-1:0]    done;
    logic            busy;
    logic [N-1:0]    dbg_pending;
    logic [TW-1:0]   dbg_ptr;

    // Handshake: requester i raises req[i] with stable operands and holds them until it sees the
    // one-cycle ack[i]; its quotient later returns on q with a one-cycle done[i]. At most one op per
    // requester is outstanding, so a held req[i] is ignored until that requester's done has fired.
    modport master (
        output req, a_in, b_in, div_q,
        input  ack, div_a, div_b, q, done, busy, dbg_pending, dbg_ptr
    );

    modport slave (
        input  req, a_in, b_in, div_q,
        output ack, div_a, div_b, q, done, busy, dbg_pending, dbg_ptr
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one pipelined fp_div among N requesters, with a tag pipe that
// routes each quotient back to its owner as a one-hot done pulse.
module div_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 16
) (
    input  logic         c,
    input  logic         rst_n,
    div_arbiter_if.slave bus
);
    localparam int TW = $clog2(N);

    logic [N-1:0]  pending;
    logic [N-1:0]  pending_nxt;
    logic [N-1:0]  elig;
    logic [N-1:0]  ack_r;
    logic [N-1:0]  done_r;
    logic [TW-1:0] ptr;
    logic [TW-1:0] gnt;
    logic          gnt_vld;
    logic [31:0]   a_sel;
    logic [31:0]   b_sel;
    logic [31:0]   div_a_r;
    logic [31:0]   div_b_r;
    logic [31:0]   q_r;
    logic [LAT:0]  pipe_vld;
    logic [TW-1:0] pipe_tag [LAT+1];
    logic          ret_vld;
    logic [TW-1:0] ret_tag;

    function automatic logic [N-1:0] onehot(input logic [TW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign elig = bus.req & ~pending;

    always_comb begin : rr_search
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!gnt_vld && elig[TW'(j)]) begin
                gnt_vld = 1'b1;
                gnt     = TW'(j);
            end
        end
    end

    always_comb begin : operand_mux
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == TW'(i)) begin
                a_sel = bus.a_in[32*i +: 32];
                b_sel = bus.b_in[32*i +: 32];
            end
        end
    end

    // Stage 0 is loaded at the grant edge and LAT more stages follow, so the tag reaches the
    // end exactly when fp_div presents the matching quotient.
    assign ret_vld = pipe_vld[LAT];
    assign ret_tag = pipe_tag[LAT];

    // A retiring tag can never equal the same-edge grant, since it is still pending.
    always_comb begin : pending_update
        pending_nxt = pending;
        if (ret_vld) begin
            pending_nxt[ret_tag] = 1'b0;
        end
        if (gnt_vld) begin
            pending_nxt[gnt] = 1'b1;
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= TW'(N - 1);
            pending  <= '0;
            ack_r    <= '0;
            div_a_r  <= '0;
            div_b_r  <= '0;
            done_r   <= '0;
            q_r      <= '0;
            pipe_vld <= '0;
        end else begin
            pending  <= pending_nxt;
            pipe_vld <= {pipe_vld[LAT-1:0], gnt_vld};
            if (gnt_vld) begin
                ack_r   <= onehot(gnt);
                div_a_r <= a_sel;
                div_b_r <= b_sel;
                ptr     <= gnt;
            end else begin
                ack_r <= '0;
            end
            if (ret_vld) begin
                q_r    <= bus.div_q;
                done_r <= onehot(ret_tag);
            end else begin
                done_r <= '0;
            end
        end
    end

    // Tags are only meaningful alongside their valid bit, so they carry no reset.
    always_ff @(posedge c) begin
        pipe_tag[0] <= gnt;
        for (int k = 1; k <= LAT; k++) begin
            pipe_tag[k] <= pipe_tag[k-1];
        end
    end

    assign bus.ack         = ack_r;
    assign bus.div_a       = div_a_r;
    assign bus.div_b       = div_b_r;
    assign bus.q           = q_r;
    assign bus.done        = done_r;
    // Busy also covers the cycle in which the last quotient is being delivered.
    assign bus.busy        = (|pending) | (|done_r);
    assign bus.dbg_pending = pending;
    assign bus.dbg_ptr     = ptr;
endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: N=4/LAT=16 main instance plus an N=2/LAT=8 instance,
// each fed by a behavioural fp_div model with the matching latency.
module tb_div_arbiter;
    localparam int N    = 4;
    localparam int LAT  = 16;
    localparam int N2   = 2;
    localparam int LAT2 = 8;
    localparam int W    = 67;
    localparam int W2   = 65;

    logic        c     = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned n_ack = 0;
    int unsigned n_done = 0;

    logic [W-1:0]  exp_q[$];
    logic [W2-1:0] exp2_q[$];
    logic [W-1:0]  sb_e;

    logic [31:0] fq  [LAT];
    logic [31:0] fq2 [LAT2];

    div_arbiter_if #(.N(N))  bus ();
    div_arbiter_if #(.N(N2)) bus2 ();

    div_arbiter #(.N(N), .LAT(LAT)) dut (
        .c     (c),
        .rst_n (rst_n),
        .bus   (bus)
    );

    div_arbiter #(.N(N2), .LAT(LAT2)) dut2 (
        .c     (c),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // ---------------- clock / reset ----------------
    always #5 c = ~c;
    always @(posedge c) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- fp_div reference ----------------
    function automatic real sp2r(input logic [31:0] s);
        logic [10:0] e;
        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        logic [31:0] r;
        d = $realtobits(sp2r(a) / sp2r(b));
        e = d[62:52] - 11'd896;
        r = {d[63], e[7:0], d[51:29]};
        if (d[28:0] > 29'h1000_0000 || (d[28:0] == 29'h1000_0000 && r[0])) r = r + 32'd1;
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r[31]    = 1'($urandom_range(0, 1));
        r[30:23] = 8'($urandom_range(120, 134));
        r[22:0]  = 23'($urandom);
        return r;
    endfunction

    // fp_div models: not reset, so stale quotients keep flowing after a reset
    always @(posedge c) begin
        fq[0] <= fdiv(bus.div_a, bus.div_b);
        for (int k = 1; k < LAT; k++) fq[k] <= fq[k-1];
        fq2[0] <= fdiv(bus2.div_a, bus2.div_b);
        for (int k = 1; k < LAT2; k++) fq2[k] <= fq2[k-1];
    end
    assign bus.div_q  = fq[LAT-1];
    assign bus2.div_q = fq2[LAT2-1];

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.a_in[32*i +: 32] = a;
        bus.b_in[32*i +: 32] = b;
    endtask

    task automatic set_op2(input int i, input logic [31:0] a, input logic [31:0] b);
        bus2.a_in[32*i +: 32] = a;
        bus2.b_in[32*i +: 32] = b;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((bus.busy || exp_q.size() != 0) && k < 200) begin
            @(negedge c);
            #2;
            k++;
        end
        total++;
        if (k >= 200) begin
            bad++;
            $display("FAIL idle_timeout busy=%b queued=%0d want idle", bus.busy, exp_q.size());
        end
    endtask

    // ---------------- scoreboard (main instance) ----------------
    always @(negedge c) begin
        if (rst_n) begin
            if (bus.ack != '0) begin
                total++;
                if ($countones(bus.ack) != 1) begin
                    bad++;
                    $display("FAIL ack_onehot ack=%b want one-hot", bus.ack);
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.ack[i]) begin
                        exp_q.push_back({cyc, 3'(i), fdiv(bus.a_in[32*i +: 32], bus.b_in[32*i +: 32])});
                        n_ack++;
                    end
                end
            end
            if (bus.done != '0) begin
                n_done++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected done=%b q=%h want no done", bus.done, bus.q);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (bus.done !== 4'(1 << sb_e[34:32]) || bus.q !== sb_e[31:0] ||
                        (cyc - sb_e[66:35]) != 32'(LAT + 1)) begin
                        bad++;
                        $display("FAIL sb_result done=%b q=%h lat=%0d want done=%b q=%h lat=%0d",
                                 bus.done, bus.q, cyc - sb_e[66:35],
                                 4'(1 << sb_e[34:32]), sb_e[31:0], LAT + 1);
                    end
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus2.req  = '0;
        bus2.a_in = '0;
        bus2.b_in = '0;
        repeat (3) @(negedge c);
        total++; if (bus.ack !== 4'b0)   begin bad++; $display("FAIL rst_ack got=%b want=0", bus.ack); end
        total++; if (bus.done !== 4'b0)  begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
        total++; if (bus.q !== 32'h0)    begin bad++; $display("FAIL rst_q got=%h want=0", bus.q); end
        total++; if (bus.div_a !== 32'h0 || bus.div_b !== 32'h0) begin
            bad++; $display("FAIL rst_div got=%h/%h want=0/0", bus.div_a, bus.div_b);
        end
        total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.dbg_ptr !== 2'd3) begin bad++; $display("FAIL rst_ptr got=%0d want=3", bus.dbg_ptr); end
        total++; if (bus2.ack !== 2'b0 || bus2.done !== 2'b0) begin
            bad++; $display("FAIL rst_small got=%b/%b want=0/0", bus2.ack, bus2.done);
        end
        #1 rst_n = 1'b1;
        @(negedge c);
        total++; if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL idle_no_req ack=%b busy=%b want 0/0", bus.ack, bus.busy);
        end
    endtask

    task automatic test_burst();
        logic [31:0]  bv [N];
        logic [31:0]  qv [N];
        logic [N-1:0] want_ack;
        logic [N-1:0] want_done;
        bv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        qv = '{32'h41200000, 32'h40A00000, 32'h40555555, 32'h40200000};
        @(negedge c);
        #1;
        for (int i = 0; i < N; i++) set_op(i, 32'h41200000, bv[i]);
        bus.req = 4'b1111;
        for (int n = 1; n <= 24; n++) begin
            @(negedge c);
            want_ack  = (n >= 1 && n <= 4) ? 4'(1 << (n - 1)) : 4'b0;
            want_done = (n >= 18 && n <= 21) ? 4'(1 << (n - 18)) : 4'b0;
            total++; if (bus.ack !== want_ack) begin
                bad++; $display("FAIL burst_ack n=%0d got=%b want=%b", n, bus.ack, want_ack);
            end
            total++; if (bus.done !== want_done) begin
                bad++; $display("FAIL burst_done n=%0d got=%b want=%b", n, bus.done, want_done);
            end
            if (n >= 18 && n <= 21) begin
                total++; if (bus.q !== qv[n-18]) begin
                    bad++; $display("FAIL burst_q n=%0d got=%h want=%h", n, bus.q, qv[n-18]);
                end
            end
            #1;
            bus.req = bus.req & ~bus.ack;
        end
    endtask

    task automatic test_single();
        logic [N-1:0] want_ack;
        logic [N-1:0] want_done;
        logic         want_busy;
        wait_idle();
        @(negedge c);
        #1;
        set_op(0, 32'h3F800000, 32'h40000000);
        bus.req = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            @(negedge c);
            want_ack  = (n == 1)  ? 4'b0001 : 4'b0;
            want_done = (n == 18) ? 4'b0001 : 4'b0;
            want_busy = (n >= 1 && n <= 18);
            total++; if (bus.ack !== want_ack) begin
                bad++; $display("FAIL single_ack n=%0d got=%b want=%b", n, bus.ack, want_ack);
            end
            total++; if (bus.done !== want_done) begin
                bad++; $display("FAIL single_done n=%0d got=%b want=%b", n, bus.done, want_done);
            end
            total++; if (bus.busy !== want_busy) begin
                bad++; $display("FAIL single_busy n=%0d got=%b want=%b", n, bus.busy, want_busy);
            end
            if (n == 18) begin
                total++; if (bus.q !== 32'h3F000000) begin
                    bad++; $display("FAIL single_q got=%h want=3f000000", bus.q);
                end
            end
            #1;
            bus.req = bus.req & ~bus.ack;
        end
    endtask

    task automatic test_round_robin();
        wait_idle();
        @(negedge c);
        #1;
        set_op(1, rand_fp(), rand_fp());
        bus.req = 4'b0010;
        @(negedge c);
        total++; if (bus.ack !== 4'b0010) begin bad++; $display("FAIL rr_first got=%b want=0010", bus.ack); end
        #1;
        set_op(0, rand_fp(), rand_fp());
        set_op(2, rand_fp(), rand_fp());
        bus.req = 4'b0101;
        @(negedge c);
        total++; if (bus.ack !== 4'b0100) begin bad++; $display("FAIL rr_second got=%b want=0100", bus.ack); end
        #1;
        bus.req = bus.req & ~bus.ack;
        @(negedge c);
        total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL rr_third got=%b want=0001", bus.ack); end
        #1;
        bus.req = bus.req & ~bus.ack;
        @(negedge c);
        total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL rr_quiet got=%b want=0000", bus.ack); end
    endtask

    task automatic test_hold_pending();
        logic [N-1:0] want_ack;
        logic [N-1:0] want_done;
        wait_idle();
        @(negedge c);
        #1;
        set_op(0, 32'h40400000, 32'h3F800000);
        bus.req = 4'b0001;
        for (int n = 1; n <= 38; n++) begin
            @(negedge c);
            want_ack  = (n == 1 || n == 19) ? 4'b0001 : (n == 18) ? 4'b0010 : 4'b0000;
            want_done = (n == 18 || n == 36) ? 4'b0001 : (n == 35) ? 4'b0010 : 4'b0000;
            total++; if (bus.ack !== want_ack) begin
                bad++; $display("FAIL hold_ack n=%0d got=%b want=%b", n, bus.ack, want_ack);
            end
            total++; if (bus.done !== want_done) begin
                bad++; $display("FAIL hold_done n=%0d got=%b want=%b", n, bus.done, want_done);
            end
            if (n == 18) begin
                total++; if (bus.q !== 32'h40400000) begin
                    bad++; $display("FAIL hold_q got=%h want=40400000", bus.q);
                end
            end
            #1;
            if (n == 17) begin
                set_op(1, rand_fp(), rand_fp());
                bus.req[1] = 1'b1;
            end
            if (bus.ack[1]) bus.req[1] = 1'b0;
            if (n == 19) bus.req[0] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int unsigned a0;
        wait_idle();
        a0 = n_ack;
        for (int n = 0; n < 300; n++) begin
            @(negedge c);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i]) begin
                    if ($urandom_range(0, 1) == 1) set_op(i, rand_fp(), rand_fp());
                    else bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
                    set_op(i, rand_fp(), rand_fp());
                    bus.req[i] = 1'b1;
                end
            end
        end
        bus.req = '0;
        wait_idle();
        total++; if (n_ack != n_done || n_ack - a0 < 20) begin
            bad++; $display("FAIL b2b_count acks=%0d dones=%0d want equal and >=20 new", n_ack, n_done);
        end
    endtask

    task automatic test_reset_mid_flight();
        wait_idle();
        @(negedge c);
        #1;
        for (int i = 0; i < 3; i++) set_op(i, rand_fp(), rand_fp());
        bus.req = 4'b0111;
        for (int n = 1; n <= 4; n++) begin
            @(negedge c);
            #1;
            bus.req = bus.req & ~bus.ack;
        end
        @(negedge c);
        rst_n   = 1'b0;
        bus.req = '0;
        exp_q.delete();
        #1;
        total++; if (bus.ack !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst_ctl ack=%b done=%b busy=%b want 0", bus.ack, bus.done, bus.busy);
        end
        total++; if (bus.q !== 32'h0 || bus.div_a !== 32'h0 || bus.div_b !== 32'h0) begin
            bad++; $display("FAIL mid_rst_data q=%h a=%h b=%h want 0", bus.q, bus.div_a, bus.div_b);
        end
        repeat (2) @(negedge c);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge c);
            total++; if (bus.done !== 4'b0) begin
                bad++; $display("FAIL stale_done n=%0d got=%b want=0", n, bus.done);
            end
        end
        total++; if (bus.q !== 32'h0) begin bad++; $display("FAIL stale_q got=%h want=0", bus.q); end
        #1;
        set_op(1, 32'h40E00000, 32'h40000000);
        bus.req = 4'b0010;
        for (int n = 1; n <= 19; n++) begin
            @(negedge c);
            if (n == 1) begin
                total++; if (bus.ack !== 4'b0010) begin bad++; $display("FAIL fresh_ack got=%b want=0010", bus.ack); end
            end
            if (n == 18) begin
                total++; if (bus.done !== 4'b0010 || bus.q !== 32'h40600000) begin
                    bad++; $display("FAIL fresh_done done=%b q=%h want 0010/40600000", bus.done, bus.q);
                end
            end
            #1;
            bus.req = bus.req & ~bus.ack;
        end
    endtask

    task automatic test_small_params();
        logic [W2-1:0] e;
        int            last;
        int            acks;
        last = 1;
        acks = 0;
        @(negedge c);
        #1;
        set_op2(0, rand_fp(), rand_fp());
        set_op2(1, rand_fp(), rand_fp());
        bus2.req = 2'b11;
        for (int n = 1; n <= 80; n++) begin
            @(negedge c);
            if (bus2.ack != 2'b00) begin
                acks++;
                total++; if (bus2.ack !== ((last == 1) ? 2'b01 : 2'b10)) begin
                    bad++; $display("FAIL small_ack n=%0d got=%b want=%b", n, bus2.ack, (last == 1) ? 2'b01 : 2'b10);
                end
                for (int i = 0; i < N2; i++) begin
                    if (bus2.ack[i]) begin
                        exp2_q.push_back({cyc, 1'(i), fdiv(bus2.a_in[32*i +: 32], bus2.b_in[32*i +: 32])});
                        last = i;
                    end
                end
            end
            if (bus2.done != 2'b00) begin
                total++;
                if (exp2_q.size() == 0) begin
                    bad++; $display("FAIL small_unexpected done=%b want none", bus2.done);
                end else begin
                    e = exp2_q.pop_front();
                    if (bus2.done !== 2'(1 << e[32]) || bus2.q !== e[31:0] ||
                        (cyc - e[64:33]) != 32'(LAT2 + 1)) begin
                        bad++;
                        $display("FAIL small_done done=%b q=%h lat=%0d want done=%b q=%h lat=%0d",
                                 bus2.done, bus2.q, cyc - e[64:33], 2'(1 << e[32]), e[31:0], LAT2 + 1);
                    end
                end
            end
            #1;
            for (int i = 0; i < N2; i++) begin
                if (bus2.ack[i]) set_op2(i, rand_fp(), rand_fp());
            end
            if (n == 60) bus2.req = 2'b00;
        end
        total++; if (exp2_q.size() != 0 || acks != 12) begin
            bad++; $display("FAIL small_totals left=%0d acks=%0d want 0 and 12", exp2_q.size(), acks);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_burst();
        test_single();
        test_round_robin();
        test_hold_pending();
        test_back_to_back();
        test_reset_mid_flight();
        test_small_params();
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
